// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: state encoding, defaults
// and the word-alignment helper.
package mem_stage_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } mem_state_e;

    localparam int unsigned TIMEOUT_DEFAULT = 16;
    localparam logic [1:0]  ALIGN_MASK      = 2'b00;

    function automatic logic is_aligned(input logic [1:0] i_low_bits);
        return i_low_bits == ALIGN_MASK;
    endfunction

endpackage

// File: rtl/mem_req_timer.sv
// Cycle counter for an outstanding memory request; o_Tc flags the last
// cycle the stage is allowed to wait for an ack.
module mem_req_timer #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic i_Clear,
    input  logic i_En,
    output logic o_Tc
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_Clear) begin
            r_count <= '0;
        end else if (i_En) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_Tc = (r_count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: word loads/stores over a req/ack handshake with timeout and
// misalignment detection, feeding the registered write-back bundle.
module mem_access_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT,
    parameter int unsigned CNT_W   = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_Valid,
    input  logic [31:0]       i_Pc,
    input  logic              i_Sig_Mem_Read,
    input  logic              i_Sig_Mem_Write,
    input  logic              i_Sig_Write_Back_Enable,
    input  logic [31:0]       i_Alu_Result,
    input  logic [31:0]       i_Val_Rm,
    input  logic [3:0]        i_Destination,
    output logic              o_Stall,
    output logic              o_Mem_Req,
    output logic              o_Mem_We,
    output logic [ADDR_W-1:0] o_Mem_Addr,
    output logic [31:0]       o_Mem_Wdata,
    input  logic              i_Mem_Ack,
    input  logic [31:0]       i_Mem_Rdata,
    output logic [31:0]       o_Pc,
    output logic              o_Sig_Write_Back_Enable,
    output logic [31:0]       o_Write_Back_Value,
    output logic [3:0]        o_Destination,
    output logic              o_Mem_Error
);

    mem_state_e        r_state, w_state_nxt;
    logic              r_req, w_req_nxt;
    logic              r_we, w_we_nxt;
    logic [ADDR_W-1:0] r_addr, w_addr_nxt;
    logic [31:0]       r_wdata, w_wdata_nxt;
    logic [31:0]       r_pc, w_pc_nxt;
    logic              r_wb_en, w_wb_en_nxt;
    logic [31:0]       r_wb_val, w_wb_val_nxt;
    logic [3:0]        r_dest, w_dest_nxt;
    logic              r_err, w_err_nxt;
    logic [31:0]       r_lat_pc, w_lat_pc_nxt;
    logic [3:0]        r_lat_dest, w_lat_dest_nxt;
    logic              r_lat_wb, w_lat_wb_nxt;

    logic w_mem_op, w_aligned, w_accept, w_tc;

    assign w_mem_op  = i_Sig_Mem_Read | i_Sig_Mem_Write;
    assign w_aligned = is_aligned(i_Alu_Result[1:0]);
    assign w_accept  = (r_state == IDLE) && i_Valid && w_mem_op && w_aligned;
    // Stall is forced low while reset is asserted so every output reads 0.
    assign o_Stall   = reset && ((r_state == ACCESS) || w_accept);

    mem_req_timer #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .i_Clear (w_accept),
        .i_En    ((r_state == ACCESS) && !i_Mem_Ack),
        .o_Tc    (w_tc)
    );

    always_comb begin
        w_state_nxt    = r_state;
        w_req_nxt      = r_req;
        w_we_nxt       = r_we;
        w_addr_nxt     = r_addr;
        w_wdata_nxt    = r_wdata;
        w_pc_nxt       = r_pc;
        w_wb_en_nxt    = 1'b0;
        w_wb_val_nxt   = r_wb_val;
        w_dest_nxt     = r_dest;
        w_err_nxt      = 1'b0;
        w_lat_pc_nxt   = r_lat_pc;
        w_lat_dest_nxt = r_lat_dest;
        w_lat_wb_nxt   = r_lat_wb;
        unique case (r_state)
            IDLE: begin
                if (i_Valid) begin
                    if (!w_mem_op) begin
                        w_pc_nxt     = i_Pc;
                        w_wb_val_nxt = i_Alu_Result;
                        w_dest_nxt   = i_Destination;
                        w_wb_en_nxt  = i_Sig_Write_Back_Enable;
                    end else if (!w_aligned) begin
                        w_pc_nxt     = i_Pc;
                        w_wb_val_nxt = i_Alu_Result;
                        w_dest_nxt   = i_Destination;
                        w_err_nxt    = 1'b1;
                    end else begin
                        w_state_nxt    = ACCESS;
                        w_req_nxt      = 1'b1;
                        w_we_nxt       = i_Sig_Mem_Write;
                        w_addr_nxt     = ADDR_W'(i_Alu_Result);
                        w_wdata_nxt    = i_Val_Rm;
                        w_lat_pc_nxt   = i_Pc;
                        w_lat_dest_nxt = i_Destination;
                        w_lat_wb_nxt   = i_Sig_Write_Back_Enable;
                    end
                end
            end
            ACCESS: begin
                // Ack takes priority over a coincident timeout.
                if (i_Mem_Ack) begin
                    w_state_nxt = IDLE;
                    w_req_nxt   = 1'b0;
                    w_pc_nxt    = r_lat_pc;
                    w_dest_nxt  = r_lat_dest;
                    if (!r_we) begin
                        w_wb_val_nxt = i_Mem_Rdata;
                        w_wb_en_nxt  = r_lat_wb;
                    end
                end else if (w_tc) begin
                    w_state_nxt = IDLE;
                    w_req_nxt   = 1'b0;
                    w_err_nxt   = 1'b1;
                    w_pc_nxt    = r_lat_pc;
                    w_dest_nxt  = r_lat_dest;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_req      <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_pc       <= '0;
            r_wb_en    <= 1'b0;
            r_wb_val   <= '0;
            r_dest     <= '0;
            r_err      <= 1'b0;
            r_lat_pc   <= '0;
            r_lat_dest <= '0;
            r_lat_wb   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_req      <= w_req_nxt;
            r_we       <= w_we_nxt;
            r_addr     <= w_addr_nxt;
            r_wdata    <= w_wdata_nxt;
            r_pc       <= w_pc_nxt;
            r_wb_en    <= w_wb_en_nxt;
            r_wb_val   <= w_wb_val_nxt;
            r_dest     <= w_dest_nxt;
            r_err      <= w_err_nxt;
            r_lat_pc   <= w_lat_pc_nxt;
            r_lat_dest <= w_lat_dest_nxt;
            r_lat_wb   <= w_lat_wb_nxt;
        end
    end

    assign o_Mem_Req               = r_req;
    assign o_Mem_We                = r_we;
    assign o_Mem_Addr              = r_addr;
    assign o_Mem_Wdata             = r_wdata;
    assign o_Pc                    = r_pc;
    assign o_Sig_Write_Back_Enable = r_wb_en;
    assign o_Write_Back_Value      = r_wb_val;
    assign o_Destination           = r_dest;
    assign o_Mem_Error             = r_err;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_Valid;
    logic [31:0] i_Pc;
    logic        i_Sig_Mem_Read;
    logic        i_Sig_Mem_Write;
    logic        i_Sig_Write_Back_Enable;
    logic [31:0] i_Alu_Result;
    logic [31:0] i_Val_Rm;
    logic [3:0]  i_Destination;
    logic        o_Stall;
    logic        o_Mem_Req;
    logic        o_Mem_We;
    logic [31:0] o_Mem_Addr;
    logic [31:0] o_Mem_Wdata;
    logic        i_Mem_Ack;
    logic [31:0] i_Mem_Rdata;
    logic [31:0] o_Pc;
    logic        o_Sig_Write_Back_Enable;
    logic [31:0] o_Write_Back_Value;
    logic [3:0]  o_Destination;
    logic        o_Mem_Error;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_access_stage #(
        .ADDR_W  (32),
        .TIMEOUT (16),
        .CNT_W   (5)
    ) dut (
        .clk                     (clk),
        .reset                   (reset),
        .i_Valid                 (i_Valid),
        .i_Pc                    (i_Pc),
        .i_Sig_Mem_Read          (i_Sig_Mem_Read),
        .i_Sig_Mem_Write         (i_Sig_Mem_Write),
        .i_Sig_Write_Back_Enable (i_Sig_Write_Back_Enable),
        .i_Alu_Result            (i_Alu_Result),
        .i_Val_Rm                (i_Val_Rm),
        .i_Destination           (i_Destination),
        .o_Stall                 (o_Stall),
        .o_Mem_Req               (o_Mem_Req),
        .o_Mem_We                (o_Mem_We),
        .o_Mem_Addr              (o_Mem_Addr),
        .o_Mem_Wdata             (o_Mem_Wdata),
        .i_Mem_Ack               (i_Mem_Ack),
        .i_Mem_Rdata             (i_Mem_Rdata),
        .o_Pc                    (o_Pc),
        .o_Sig_Write_Back_Enable (o_Sig_Write_Back_Enable),
        .o_Write_Back_Value      (o_Write_Back_Value),
        .o_Destination           (o_Destination),
        .o_Mem_Error             (o_Mem_Error)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic rd, input logic wr,
                         input logic wb, input logic [31:0] alu, input logic [31:0] rm,
                         input logic [3:0] dst);
        i_Valid = v; i_Pc = pc; i_Sig_Mem_Read = rd; i_Sig_Mem_Write = wr;
        i_Sig_Write_Back_Enable = wb; i_Alu_Result = alu; i_Val_Rm = rm; i_Destination = dst;
    endtask

    task automatic test_reset();
        reset = 1'b0; i_Mem_Ack = 1'b0; i_Mem_Rdata = 32'h1234_5678;
        drive(1'b1, 32'hDEAD_0000, 1'b1, 1'b0, 1'b1, 32'h0000_0100, 32'h1111_2222, 4'h7);
        tick(); tick();
        checks++;
        if ({o_Stall, o_Mem_Req, o_Mem_We, o_Mem_Addr, o_Mem_Wdata, o_Pc,
             o_Sig_Write_Back_Enable, o_Write_Back_Value, o_Destination, o_Mem_Error} !== '0) begin
            errors++; $display("FAIL reset_outputs: stall=%b req=%b we=%b addr=%h pc=%h wb=%b val=%h dst=%h err=%b, required all 0",
                o_Stall, o_Mem_Req, o_Mem_We, o_Mem_Addr, o_Pc, o_Sig_Write_Back_Enable,
                o_Write_Back_Value, o_Destination, o_Mem_Error);
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        #1 reset = 1'b1;
        tick(); tick();
        checks++;
        if ({o_Stall, o_Mem_Req, o_Pc, o_Sig_Write_Back_Enable, o_Write_Back_Value,
             o_Destination, o_Mem_Error} !== '0) begin
            errors++; $display("FAIL reset_release: stall=%b req=%b pc=%h wb=%b val=%h, required all 0",
                o_Stall, o_Mem_Req, o_Pc, o_Sig_Write_Back_Enable, o_Write_Back_Value);
        end
    endtask

    task automatic test_passthrough();
        drive(1'b1, 32'h1000, 1'b0, 1'b0, 1'b1, 32'hABCD_1234, 32'h0, 4'hA);
        #1; checks++;
        if (o_Stall !== 1'b0) begin errors++; $display("FAIL alu_stall: got %b want 0", o_Stall); end
        tick(); checks++;
        if (o_Pc !== 32'h1000 || o_Write_Back_Value !== 32'hABCD_1234 || o_Destination !== 4'hA ||
            o_Sig_Write_Back_Enable !== 1'b1 || o_Mem_Req !== 1'b0) begin
            errors++; $display("FAIL alu_pass: pc=%h val=%h dst=%h wb=%b req=%b want 1000/abcd1234/a/1/0",
                o_Pc, o_Write_Back_Value, o_Destination, o_Sig_Write_Back_Enable, o_Mem_Req);
        end
        drive(1'b1, 32'h1040, 1'b0, 1'b0, 1'b0, 32'h0000_0042, 32'h0, 4'h3);
        tick(); checks++;
        if (o_Pc !== 32'h1040 || o_Write_Back_Value !== 32'h42 || o_Destination !== 4'h3 ||
            o_Sig_Write_Back_Enable !== 1'b0) begin
            errors++; $display("FAIL alu_back_to_back: pc=%h val=%h dst=%h wb=%b want 1040/42/3/0",
                o_Pc, o_Write_Back_Value, o_Destination, o_Sig_Write_Back_Enable);
        end
        drive(1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0, 4'hF);
        tick(); checks++;
        if (o_Pc !== 32'h1040 || o_Write_Back_Value !== 32'h42 || o_Destination !== 4'h3 ||
            o_Sig_Write_Back_Enable !== 1'b0) begin
            errors++; $display("FAIL bubble_hold: pc=%h val=%h dst=%h wb=%b want 1040/42/3/0",
                o_Pc, o_Write_Back_Value, o_Destination, o_Sig_Write_Back_Enable);
        end
    endtask

    task automatic test_load();
        drive(1'b1, 32'h1004, 1'b1, 1'b0, 1'b1, 32'h0000_0200, 32'h0, 4'h5);
        #1; checks++;
        if (o_Stall !== 1'b1) begin errors++; $display("FAIL load_accept_stall: got %b want 1", o_Stall); end
        for (int c = 1; c <= 3; c++) begin
            tick();
            if (c == 3) begin
                i_Mem_Ack = 1'b1; i_Mem_Rdata = 32'h5566_7788; i_Valid = 1'b0;
                #1;
            end
            checks++;
            if (o_Mem_Req !== 1'b1 || o_Mem_Addr !== 32'h200 || o_Mem_We !== 1'b0 ||
                o_Stall !== 1'b1 || o_Sig_Write_Back_Enable !== 1'b0) begin
                errors++; $display("FAIL load_access_c%0d: req=%b addr=%h we=%b stall=%b wb=%b want 1/200/0/1/0",
                    c, o_Mem_Req, o_Mem_Addr, o_Mem_We, o_Stall, o_Sig_Write_Back_Enable);
            end
        end
        tick();
        i_Mem_Ack = 1'b0;
        #1; checks++;
        if (o_Write_Back_Value !== 32'h5566_7788 || o_Destination !== 4'h5 || o_Pc !== 32'h1004 ||
            o_Sig_Write_Back_Enable !== 1'b1 || o_Mem_Req !== 1'b0 || o_Stall !== 1'b0 ||
            o_Mem_Error !== 1'b0) begin
            errors++; $display("FAIL load_done: val=%h dst=%h pc=%h wb=%b req=%b stall=%b err=%b want 55667788/5/1004/1/0/0/0",
                o_Write_Back_Value, o_Destination, o_Pc, o_Sig_Write_Back_Enable, o_Mem_Req,
                o_Stall, o_Mem_Error);
        end
    endtask

    task automatic test_store();
        drive(1'b1, 32'h1008, 1'b0, 1'b1, 1'b1, 32'h0000_0300, 32'hFFEE_DDCC, 4'h3);
        tick(); checks++;
        if (o_Mem_Req !== 1'b1 || o_Mem_We !== 1'b1 || o_Mem_Addr !== 32'h300 ||
            o_Mem_Wdata !== 32'hFFEE_DDCC) begin
            errors++; $display("FAIL store_req: req=%b we=%b addr=%h wdata=%h want 1/1/300/ffeeddcc",
                o_Mem_Req, o_Mem_We, o_Mem_Addr, o_Mem_Wdata);
        end
        i_Mem_Ack = 1'b1; i_Mem_Rdata = 32'h0BAD_0BAD; i_Valid = 1'b0;
        tick();
        i_Mem_Ack = 1'b0;
        checks++;
        if (o_Mem_Req !== 1'b0 || o_Sig_Write_Back_Enable !== 1'b0 || o_Mem_Error !== 1'b0 ||
            o_Pc !== 32'h1008 || o_Destination !== 4'h3) begin
            errors++; $display("FAIL store_done: req=%b wb=%b err=%b pc=%h dst=%h want 0/0/0/1008/3",
                o_Mem_Req, o_Sig_Write_Back_Enable, o_Mem_Error, o_Pc, o_Destination);
        end
    endtask

    task automatic test_misaligned();
        drive(1'b1, 32'h100C, 1'b1, 1'b0, 1'b1, 32'h0000_0202, 32'h0, 4'h6);
        #1; checks++;
        if (o_Stall !== 1'b0) begin errors++; $display("FAIL misalign_stall: got %b want 0", o_Stall); end
        tick(); checks++;
        if (o_Mem_Req !== 1'b0 || o_Mem_Error !== 1'b1 || o_Sig_Write_Back_Enable !== 1'b0) begin
            errors++; $display("FAIL misalign: req=%b err=%b wb=%b want 0/1/0",
                o_Mem_Req, o_Mem_Error, o_Sig_Write_Back_Enable);
        end
        i_Valid = 1'b0;
        tick(); checks++;
        if (o_Mem_Error !== 1'b0) begin errors++; $display("FAIL misalign_pulse: err=%b want 0", o_Mem_Error); end
    endtask

    task automatic test_timeout();
        int n;
        drive(1'b1, 32'h1010, 1'b1, 1'b0, 1'b1, 32'h0000_0400, 32'h0, 4'h9);
        tick();
        i_Valid = 1'b0;
        n = 0;
        while (o_Mem_Req === 1'b1 && n < 40) begin
            n++;
            tick();
        end
        checks++;
        if (n !== 16) begin errors++; $display("FAIL timeout_len: req cycles=%0d want 16", n); end
        checks++;
        if (o_Mem_Req !== 1'b0 || o_Mem_Error !== 1'b1 || o_Sig_Write_Back_Enable !== 1'b0 ||
            o_Stall !== 1'b0) begin
            errors++; $display("FAIL timeout_end: req=%b err=%b wb=%b stall=%b want 0/1/0/0",
                o_Mem_Req, o_Mem_Error, o_Sig_Write_Back_Enable, o_Stall);
        end
        tick(); checks++;
        if (o_Mem_Error !== 1'b0) begin errors++; $display("FAIL timeout_pulse: err=%b want 0", o_Mem_Error); end
    endtask

    task automatic test_ack_at_timeout();
        drive(1'b1, 32'h1014, 1'b1, 1'b0, 1'b1, 32'h0000_0500, 32'h0, 4'hC);
        tick();
        i_Valid = 1'b0;
        for (int c = 0; c < 15; c++) tick();
        i_Mem_Ack = 1'b1; i_Mem_Rdata = 32'hCAFE_F00D;
        tick();
        i_Mem_Ack = 1'b0;
        checks++;
        if (o_Mem_Error !== 1'b0 || o_Sig_Write_Back_Enable !== 1'b1 ||
            o_Write_Back_Value !== 32'hCAFE_F00D || o_Destination !== 4'hC || o_Mem_Req !== 1'b0) begin
            errors++; $display("FAIL ack_wins: err=%b wb=%b val=%h dst=%h req=%b want 0/1/cafef00d/c/0",
                o_Mem_Error, o_Sig_Write_Back_Enable, o_Write_Back_Value, o_Destination, o_Mem_Req);
        end
    endtask

    task automatic test_reset_mid_access();
        drive(1'b1, 32'h1018, 1'b1, 1'b0, 1'b1, 32'h0000_0600, 32'h0, 4'hE);
        tick(); tick();
        reset = 1'b0; i_Valid = 1'b0;
        tick(); checks++;
        if ({o_Stall, o_Mem_Req, o_Mem_Addr, o_Pc, o_Sig_Write_Back_Enable, o_Write_Back_Value,
             o_Destination, o_Mem_Error} !== '0) begin
            errors++; $display("FAIL reset_mid: stall=%b req=%b addr=%h pc=%h val=%h want all 0",
                o_Stall, o_Mem_Req, o_Mem_Addr, o_Pc, o_Write_Back_Value);
        end
        reset = 1'b1;
        tick();
        i_Mem_Ack = 1'b1; i_Mem_Rdata = 32'h7777_7777;
        tick();
        i_Mem_Ack = 1'b0;
        tick(); checks++;
        if ({o_Stall, o_Mem_Req, o_Pc, o_Sig_Write_Back_Enable, o_Write_Back_Value,
             o_Destination, o_Mem_Error} !== '0) begin
            errors++; $display("FAIL late_ack: stall=%b req=%b pc=%h wb=%b val=%h err=%b want all 0",
                o_Stall, o_Mem_Req, o_Pc, o_Sig_Write_Back_Enable, o_Write_Back_Value, o_Mem_Error);
        end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_load();
        test_store();
        test_misaligned();
        test_timeout();
        test_ack_at_timeout();
        test_reset_mid_access();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
